// File: rtl/muldiv_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Datapath engine: 2*WIDTH shift register, iteration counter and the
// shift-add multiply / restoring divide step. Operands are unsigned magnitudes.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               is_div_i,
    input  logic               run_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_val;

    // One iteration of either algorithm, selected by the captured op kind
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        step_val  = acc_q;
        if (is_div_q) begin
            // Borrow out of the trial subtraction means "restore"
            if (div_diff[WIDTH] == 1'b0) begin
                step_val = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_val = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_val = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Load operands on a start, advance one step per RUN cycle
    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            // Low half holds the multiplier or the dividend; opnd the other operand
            acc_d    = {{WIDTH{1'b0}}, (is_div_i ? opa_i : opb_i)};
            opnd_d   = is_div_i ? opb_i : opa_i;
            is_div_d = is_div_i;
            cnt_d    = {CW{1'b0}};
        end else if (run_i) begin
            acc_d = step_val;
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Engine state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_o = run_i && (cnt_q == CW'(WIDTH - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO with a start/busy/done handshake.
// Signed MULT/DIV are built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;
    logic               is_div_q, is_div_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;

    logic               load;
    logic               ld_div;
    logic               last;
    logic [WIDTH-1:0]   opa_mag;
    logic [WIDTH-1:0]   opb_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic               sgn_op;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    // Magnitudes for signed ops; the most-negative value maps to 2^(WIDTH-1)
    always_comb begin
        sgn_op  = (op == OP_MULT) || (op == OP_DIV);
        opa_mag = (sgn_op && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
        opb_mag = (sgn_op && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    end

    // Sign fix-up; remainder follows the dividend
    always_comb begin
        prod_fix = neg_res_q ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
        quo_fix  = neg_res_q ? (~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                             : acc[2*WIDTH-1:WIDTH];
    end

    // Sign flags captured with the operands
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign opa_mag  = a;
    assign opb_mag  = b;
    assign prod_fix = acc;
    assign quo_fix  = acc[WIDTH-1:0];
    assign rem_fix  = acc[2*WIDTH-1:WIDTH];
`endif

    // FSM next state, op decode, HI/LO updates
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        b_zero_d = b_zero_q;
        dvd_d    = dvd_q;
        load     = 1'b0;
        ld_div   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            load = 1'b1;
                        end
                        OP_DIVU: begin
                            load   = 1'b1;
                            ld_div = 1'b1;
                        end
`ifdef MULDIV_SIGNED_EN
                        OP_MULT: begin
                            load = 1'b1;
                        end
                        OP_DIV: begin
                            load   = 1'b1;
                            ld_div = 1'b1;
                        end
`endif
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                    if (load) begin
                        state_d  = ST_RUN;
                        is_div_d = ld_div;
                        b_zero_d = (b == {WIDTH{1'b0}});
                        dvd_d    = a;
`ifdef MULDIV_SIGNED_EN
                        neg_res_d = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = sgn_op && a[WIDTH-1];
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (is_div_q) begin
                    if (b_zero_q) begin
                        lo_d = {WIDTH{1'b1}};
                        hi_d = dvd_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_FINISH);
        div0_d = (state_q == ST_FINISH) && is_div_q && b_zero_q;
    end

    // Architectural and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            dvd_q    <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            is_div_q <= is_div_d;
            b_zero_q <= b_zero_d;
            dvd_q    <= dvd_d;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .is_div_i (ld_div),
        .run_i    (state_q == ST_RUN),
        .opa_i    (opa_mag),
        .opb_i    (opb_mag),
        .last_o   (last),
        .acc_o    (acc)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
